// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Groups the three buses the dmem arbiter sits between: the core's M-stage
//   load/store port (cpu_*), the external requester (ext_*) and the
//   single-port data memory (mem_*).
//
//   Handshake rules:
//     - CPU side: the core presents cpu_req with its address and data. It must
//       hold the request unchanged while cpu_stall=1. The access takes place
//       in the first cycle that has cpu_req=1 and cpu_stall=0.
//     - EXT side: a beat transfers on a cycle with ext_valid & ext_ready.
//       ext_ready never depends on the beat's data. For an accepted read,
//       ext_rd is valid during the single-cycle ext_rvalid pulse on the next
//       cycle.
//     - MEM side: mem_rd is a combinational read of mem_a. The memory writes
//       on the posedge whenever mem_we=1.
//
//   Modports:
//     slave  - the arbiter. It receives the cpu/ext requests, drives the
//              responses and mem_*, and receives mem_rd.
//     master - the environment (core, ext requester, dmem).
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [2:0]        cpu_mode;
    logic [ADDR_W-1:0] cpu_adrs;
    logic [DATA_W-1:0] cpu_wd;
    logic [DATA_W-1:0] cpu_rd;
    logic              cpu_stall;

    logic              ext_valid;
    logic              ext_lock;
    logic              ext_we;
    logic [2:0]        ext_mode;
    logic [ADDR_W-1:0] ext_adrs;
    logic [DATA_W-1:0] ext_wd;
    logic              ext_ready;
    logic [DATA_W-1:0] ext_rd;
    logic              ext_rvalid;

    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_we;
    logic [2:0]        mem_mode;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_mode, cpu_adrs, cpu_wd,
        output cpu_rd, cpu_stall,
        input  ext_valid, ext_lock, ext_we, ext_mode, ext_adrs, ext_wd,
        output ext_ready, ext_rd, ext_rvalid,
        output mem_a, mem_wd, mem_we, mem_mode,
        input  mem_rd
    );

    modport master (
        output cpu_req, cpu_we, cpu_mode, cpu_adrs, cpu_wd,
        input  cpu_rd, cpu_stall,
        output ext_valid, ext_lock, ext_we, ext_mode, ext_adrs, ext_wd,
        input  ext_ready, ext_rd, ext_rvalid,
        input  mem_a, mem_wd, mem_we, mem_mode,
        output mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port dmem between the core's M-stage load/store port and
//   an external requester (program loader / debug DMA).
//
//   Arbitration:
//     - The CPU has priority in IDLE.
//     - The external side can lock ownership for a burst of up to BURST_MAX
//       beats. During the burst the core sees cpu_stall.
//
//   Optional feature (macro DMEM_ARB_FAIRNESS_EN):
//     A starvation counter forces a single ext beat after STARVE_MAX cycles in
//     which the ext side waited without a grant.
//
//   Ports:
//     clk              - clock; all state updates on posedge
//     reset            - synchronous, active-low
//     bus              - dmem_arbiter_if.slave (cpu_*, ext_*, mem_*)
//     o_dbg_state      - FSM state (0 = IDLE, 1 = EXT_BURST)
//     o_dbg_beat_cnt   - beats granted so far in the current locked burst
//     o_dbg_starve_cnt - ext starvation counter (zero when the feature is off)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BURST_MAX  = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                                               clk,
    input  logic                                               reset,
    dmem_arbiter_if.slave                                      bus,
    output logic                                               o_dbg_state,
    output logic [((BURST_MAX > 1) ? $clog2(BURST_MAX) : 1)-1:0] o_dbg_beat_cnt,
    output logic [$clog2(STARVE_MAX + 1)-1:0]                  o_dbg_starve_cnt
);
    localparam int BCNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam int SCNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BURST_MAX - 1);
    localparam bit BURST_EN = (BURST_MAX > 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [BCNT_W-1:0]  r_beat_cnt, w_beat_nxt;
    logic               w_cpu_grant, w_ext_grant, w_force_ext;
    logic [ADDR_W-1:0]  w_mem_a;
    logic [DATA_W-1:0]  w_mem_wd;
    logic               w_mem_we;
    logic [2:0]         w_mem_mode;
    logic [DATA_W-1:0]  r_ext_rd;
    logic               r_ext_rvalid;

`ifdef DMEM_ARB_FAIRNESS_EN
    logic [SCNT_W-1:0] r_starve_cnt;

    // A pending-but-ungranted ext request ages. Any ext grant, or a dropped
    // ext_valid, clears the age.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (!bus.ext_valid || w_ext_grant) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != SCNT_W'(STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + SCNT_W'(1);
        end
    end

    assign w_force_ext      = (r_starve_cnt == SCNT_W'(STARVE_MAX));
    assign o_dbg_starve_cnt = r_starve_cnt;
`else
    assign w_force_ext      = 1'b0;
    assign o_dbg_starve_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    // Grant and next-state logic. Everything is gated off while reset is low,
    // so a burst that is interrupted by reset never produces a write.
    always_comb begin
        w_cpu_grant = 1'b0;
        w_ext_grant = 1'b0;
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        if (reset) begin
            if (w_force_ext && bus.ext_valid) begin
                // Forced fairness beat: a single beat only, and ext_lock is
                // ignored.
                w_ext_grant = 1'b1;
                w_state_nxt = ST_IDLE;
                w_beat_nxt  = '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (bus.cpu_req) begin
                            w_cpu_grant = 1'b1;
                        end else if (bus.ext_valid) begin
                            w_ext_grant = 1'b1;
                            if (BURST_EN && bus.ext_lock) begin
                                w_state_nxt = ST_BURST;
                                w_beat_nxt  = BCNT_W'(1);
                            end
                        end
                    end
                    ST_BURST: begin
                        if (bus.ext_valid) begin
                            w_ext_grant = 1'b1;
                            if (!bus.ext_lock || r_beat_cnt == BEAT_LAST) begin
                                w_state_nxt = ST_IDLE;
                                w_beat_nxt  = '0;
                            end else begin
                                w_beat_nxt  = r_beat_cnt + BCNT_W'(1);
                            end
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_beat_nxt  = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_beat_nxt  = '0;
                    end
                endcase
            end
        end
    end

    // Memory mux. With no grant the bus is driven to zero, so that a
    // requester that did not win can never cause a write.
    always_comb begin
        w_mem_a    = '0;
        w_mem_wd   = '0;
        w_mem_we   = 1'b0;
        w_mem_mode = 3'd0;
        if (w_cpu_grant) begin
            w_mem_a    = bus.cpu_adrs;
            w_mem_wd   = bus.cpu_wd;
            w_mem_we   = bus.cpu_we;
            w_mem_mode = bus.cpu_mode;
        end else if (w_ext_grant) begin
            w_mem_a    = bus.ext_adrs;
            w_mem_wd   = bus.ext_wd;
            w_mem_we   = bus.ext_we;
            w_mem_mode = bus.ext_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ext_rd     <= '0;
            r_ext_rvalid <= 1'b0;
        end else if (w_ext_grant && !bus.ext_we) begin
            r_ext_rd     <= bus.mem_rd;
            r_ext_rvalid <= 1'b1;
        end else begin
            r_ext_rvalid <= 1'b0;
        end
    end

    assign bus.mem_a      = w_mem_a;
    assign bus.mem_wd     = w_mem_wd;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_mode   = w_mem_mode;
    assign bus.cpu_rd     = bus.mem_rd;
    assign bus.cpu_stall  = reset & bus.cpu_req & ~w_cpu_grant;
    assign bus.ext_ready  = w_ext_grant;
    assign bus.ext_rd     = r_ext_rd;
    assign bus.ext_rvalid = r_ext_rvalid;

    assign o_dbg_state    = r_state;
    assign o_dbg_beat_cnt = r_beat_cnt;
endmodule
